// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// A control word packs the eight pipeline-register control lines in one fixed order.
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic pc_sel;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_bubble;
    } ctl_t;

    localparam ctl_t CTL_RUN      = 8'b1010_1010;
    localparam ctl_t CTL_RESET    = 8'b0001_0101;
    localparam ctl_t CTL_MEM_WAIT = 8'b0000_0001;
    localparam ctl_t CTL_REDIRECT = 8'b1111_1110;
    localparam ctl_t CTL_FLUSH    = 8'b1011_1110;
    localparam ctl_t CTL_LOAD_USE = 8'b0000_1110;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the load in EX writes a register that the ID instruction reads.
// Register 0 is hardwired to zero, so a load into it never creates a dependency.
import mips_pkg::*;

module hazard_detect (
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    output logic                  load_use_o
);

    assign load_use_o = ex_mem_read_i && (ex_rt_i != '0) &&
                        ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubble, redirect flush,
// data-memory wait with timeout flag, and a saturating stall-cycle counter.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_RUN      | normal issue; resolves mem wait > redirect > load-use
//   ST_MEM_WAIT | pipeline frozen until data memory reports ready
//   ST_FLUSH    | extra IF/ID + ID/EX flush cycles after a redirect
import mips_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  id_rs_i,
    input  logic [REG_ADDR_W-1:0]  id_rt_i,
    input  logic                   id_uses_rt_i,
    input  logic                   ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0]  ex_rt_i,
    input  logic                   ex_redirect_i,
    input  logic                   mem_access_i,
    input  logic                   mem_ready_i,
    output logic                   pc_en_o,
    output logic                   pc_sel_o,
    output logic                   ifid_en_o,
    output logic                   ifid_flush_o,
    output logic                   idex_en_o,
    output logic                   idex_flush_o,
    output logic                   exmem_en_o,
    output logic                   memwb_bubble_o,
    output logic [1:0]             state_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   mem_err_o
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t         state;
    state_t         state_nxt;
    logic [FCW-1:0] flush_cnt;
    logic [FCW-1:0] flush_cnt_nxt;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_cnt_nxt;
    logic           err_nxt;
    logic           load_use;
    logic           mem_stall;
    logic           stall_event;
    ctl_t           ctl;

    hazard_detect u_hazard_detect (
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_uses_rt_i  (id_uses_rt_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rt_i       (ex_rt_i),
        .load_use_o    (load_use)
    );

    assign mem_stall = mem_access_i && !mem_ready_i;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wait_cnt_nxt  = wait_cnt;
        err_nxt       = mem_err_o;
        ctl           = CTL_RUN;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    ctl          = CTL_MEM_WAIT;
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WCW'(1);
                end else if (ex_redirect_i) begin
                    ctl = CTL_REDIRECT;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt     = ST_FLUSH;
                        flush_cnt_nxt = FCW'(FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    ctl = CTL_LOAD_USE;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_nxt = ST_RUN;
                end else begin
                    ctl = CTL_MEM_WAIT;
                    // counter parks at MEM_TIMEOUT; the flag is what matters after that
                    if (wait_cnt < WCW'(MEM_TIMEOUT))
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    if (wait_cnt >= WCW'(MEM_TIMEOUT - 1))
                        err_nxt = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (mem_stall) begin
                    ctl          = CTL_MEM_WAIT;
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WCW'(1);
                end else begin
                    ctl = CTL_FLUSH;
                    if (flush_cnt <= FCW'(1))
                        state_nxt = ST_RUN;
                    else
                        flush_cnt_nxt = flush_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
        if (reset)
            ctl = CTL_RESET;
    end

    assign stall_event = !ctl.pc_en || ctl.ifid_flush || ctl.idex_flush || ctl.memwb_bubble;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err_o <= err_nxt;
            if (stall_event && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    assign pc_en_o        = ctl.pc_en;
    assign pc_sel_o       = ctl.pc_sel;
    assign ifid_en_o      = ctl.ifid_en;
    assign ifid_flush_o   = ctl.ifid_flush;
    assign idex_en_o      = ctl.idex_en;
    assign idex_flush_o   = ctl.idex_flush;
    assign exmem_en_o     = ctl.exmem_en;
    assign memwb_bubble_o = ctl.memwb_bubble;
    assign state_o        = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// random traffic, all compared against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int FC   = 2;
    localparam int TO   = 4;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_mem_read, ex_redirect, mem_access, mem_ready;
    logic          pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;
    logic [1:0]    state;
    logic [SW-1:0] stall_cnt;
    logic          mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    // model: mode 0=run 1=waiting on memory 2=extra flush cycles
    int m_mode, m_wait, m_left, m_err, m_stall;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO), .STALL_CNT_W(SW)) dut (
        .clk(clk), .reset(reset),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_mem_read_i(ex_mem_read), .ex_rt_i(ex_rt), .ex_redirect_i(ex_redirect),
        .mem_access_i(mem_access), .mem_ready_i(mem_ready),
        .pc_en_o(pc_en), .pc_sel_o(pc_sel), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush),
        .idex_en_o(idex_en), .idex_flush_o(idex_flush), .exmem_en_o(exmem_en),
        .memwb_bubble_o(memwb_bubble), .state_o(state), .stall_cnt_o(stall_cnt),
        .mem_err_o(mem_err)
    );

    // {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
    function automatic logic [7:0] exp_ctl();
        bit lu, ms;
        lu = ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        ms = mem_access && !mem_ready;
        if (reset)       return 8'b0001_0101;
        if (m_mode == 1) return mem_ready ? 8'b1010_1010 : 8'b0000_0001;
        if (ms)          return 8'b0000_0001;
        if (m_mode == 2) return 8'b1011_1110;
        if (ex_redirect) return 8'b1111_1110;
        if (lu)          return 8'b0000_1110;
        return 8'b1010_1010;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] obs;
        obs = {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble};
        check({tag, ":ctl"},   16'(obs),       16'(exp_ctl()));
        check({tag, ":state"}, 16'(state),     16'(m_mode));
        check({tag, ":stall"}, 16'(stall_cnt), 16'(m_stall));
        check({tag, ":err"},   16'(mem_err),   16'(m_err));
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_left = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic model_step(input logic [7:0] e);
        bit ms;
        ms = mem_access && !mem_ready;
        if ((!e[7] || e[4] || e[2] || e[0]) && m_stall < SMAX) m_stall++;
        case (m_mode)
            0: if (ms) begin
                   m_mode = 1; m_wait = 1;
               end else if (ex_redirect && FC > 1) begin
                   m_mode = 2; m_left = FC - 1;
               end
            1: if (mem_ready) m_mode = 0;
               else begin
                   m_wait++;
                   if (m_wait >= TO) m_err = 1;
               end
            default: if (ms) begin
                   m_mode = 1; m_wait = 1;
               end else if (m_left <= 1) m_mode = 0;
               else m_left--;
        endcase
    endtask

    task automatic set_in(input int rs, input int rt, input bit uses, input bit mrd,
                          input int ert, input bit redir, input bit macc, input bit mrdy);
        id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = uses; ex_mem_read = mrd;
        ex_rt = 5'(ert); ex_redirect = redir; mem_access = macc; mem_ready = mrdy;
    endtask

    // called shortly after a rising edge; checks mid-cycle, then advances one cycle
    task automatic tick(input string tag);
        logic [7:0] e;
        #1;
        e = exp_ctl();
        check_all(tag);
        @(posedge clk);
        model_step(e);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, "_async"});
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        check_all("reset_held");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // load-use on rs, then the bubble has entered EX
        set_in(8, 9, 0, 1, 8, 0, 0, 1);  tick("t1_lu");
        set_in(8, 9, 0, 0, 0, 0, 0, 1);  tick("t1_after");

        // no stall for $zero or an rt match when rt is not read
        set_in(0, 0, 1, 1, 0, 0, 0, 0);  tick("t2_rt0");
        set_in(3, 8, 0, 1, 8, 0, 0, 0);  tick("t2_rt_unused");
        set_in(3, 8, 1, 1, 8, 0, 0, 0);  tick("t2_rt_used");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);  tick("t2_idle");

        // redirect with two flush cycles
        set_in(0, 0, 0, 0, 0, 1, 0, 0);  tick("t3_redir");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);  tick("t3_flush");
        tick("t3_back");

        // three-cycle memory wait with a load-use pending behind it
        set_in(8, 0, 0, 1, 8, 0, 1, 0);
        repeat (3) tick("t4_wait");
        set_in(8, 0, 0, 1, 8, 0, 1, 1);  tick("t4_ready");
        set_in(8, 0, 0, 1, 8, 0, 0, 0);  tick("t4_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);  tick("t4_idle");

        // memory never ready: timeout flag sets and sticks, reset clears it
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (7) tick("t5_wait");
        pulse_reset("t5_rst");

        // redirect wins over load-use, then reset lands in the middle of FLUSH
        set_in(8, 0, 0, 1, 8, 1, 0, 0);  tick("t6_both");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        pulse_reset("t6_rst_flush");
        tick("t6_after");

        for (int i = 0; i < 400; i++) begin
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rt       = 5'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 5) == 0);
            mem_access  = ($urandom_range(0, 2) == 0);
            mem_ready   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 60) == 0)
                pulse_reset("rnd_rst");
            else
                tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
